ram_arbiter: RTL

RAM_ARBITER -- requirements
Module: ram_arbiter

---
 rtl/ram_arbiter_if.sv | 38 +++
 rtl/ram_arbiter.sv | 120 ++++++++++++
 2 files changed

// File: rtl/ram_arbiter_if.sv
// CPU / video / RAM bus bundle for ram_arbiter.
// slave = the arbiter, master = the surrounding system (CPU, video, RAM).
interface ram_arbiter_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 8
);
  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_din;
  logic [DATA_W-1:0] cpu_dout;
  logic              cpu_ack;
  logic              cpu_wait;

  logic              vid_req;
  logic [ADDR_W-1:0] vid_addr;
  logic [DATA_W-1:0] vid_q;
  logic              vid_valid;

  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_din;
  logic              ram_rd_n;
  logic              ram_wr_n;
  logic              ram_ce_n;
  logic [DATA_W-1:0] ram_q;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_din, vid_req, vid_addr, ram_q,
    output cpu_dout, cpu_ack, cpu_wait, vid_q, vid_valid,
           ram_addr, ram_din, ram_rd_n, ram_wr_n, ram_ce_n
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_din, vid_req, vid_addr, ram_q,
    input  cpu_dout, cpu_ack, cpu_wait, vid_q, vid_valid,
           ram_addr, ram_din, ram_rd_n, ram_wr_n, ram_ce_n
  );
endinterface

// File: rtl/ram_arbiter.sv
// Two-port arbiter sharing one asynchronous-style RAM between a CPU and a
// video fetcher. Reads take VRD/CRD (strobe) + VCAP/CCAP (capture); writes
// take a single CWR cycle. All RAM-side outputs are registered.
module ram_arbiter #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 8
) (
  input  logic         clk,
  input  logic         reset_n,
  ram_arbiter_if.slave bus
);

  typedef enum logic [2:0] {IDLE, VRD, VCAP, CRD, CCAP, CWR} state_e;

  state_e            state_q, state_d;
  logic              last_vid_q, last_vid_d;
  logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
  logic [DATA_W-1:0] ram_din_q, ram_din_d;
  logic [DATA_W-1:0] cpu_dout_q, cpu_dout_d;
  logic [DATA_W-1:0] vid_data_q, vid_data_d;
  logic              rd_n_q, rd_n_d;
  logic              wr_n_q, wr_n_d;
  logic              ce_n_q, ce_n_d;
  logic              cpu_ack_q, cpu_ack_d;
  logic              vid_valid_q, vid_valid_d;
  logic              vid_pend, cpu_pend;

  // A port whose completion pulse is still high is finishing, not requesting.
  assign vid_pend = bus.vid_req & ~vid_valid_q;
  assign cpu_pend = bus.cpu_req & ~cpu_ack_q;

  // Next-state, grant and capture logic; strobes follow the next state so
  // they are registered in step with the FSM.
  always_comb begin
    state_d     = state_q;
    last_vid_d  = last_vid_q;
    ram_addr_d  = ram_addr_q;
    ram_din_d   = ram_din_q;
    cpu_dout_d  = cpu_dout_q;
    vid_data_d  = vid_data_q;
    cpu_ack_d   = 1'b0;
    vid_valid_d = 1'b0;
    case (state_q)
      IDLE: begin
        // Video wins a tie unless it took the previous grant.
        if (vid_pend && (!cpu_pend || !last_vid_q)) begin
          state_d    = VRD;
          ram_addr_d = bus.vid_addr;
          last_vid_d = 1'b1;
        end else if (cpu_pend) begin
          state_d    = bus.cpu_we ? CWR : CRD;
          ram_addr_d = bus.cpu_addr;
          if (bus.cpu_we) ram_din_d = bus.cpu_din;
          last_vid_d = 1'b0;
        end
      end
      VRD:  state_d = VCAP;
      VCAP: begin
        vid_data_d  = bus.ram_q;
        vid_valid_d = 1'b1;
        state_d     = IDLE;
      end
      CRD:  state_d = CCAP;
      CCAP: begin
        cpu_dout_d = bus.ram_q;
        cpu_ack_d  = 1'b1;
        state_d    = IDLE;
      end
      CWR: begin
        cpu_ack_d = 1'b1;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
    rd_n_d = !(state_d == VRD || state_d == CRD);
    wr_n_d = (state_d != CWR);
    ce_n_d = (state_d == IDLE);
  end

  // State and output registers; reset aborts any access in flight.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      last_vid_q  <= 1'b0;
      ram_addr_q  <= '0;
      ram_din_q   <= '0;
      cpu_dout_q  <= '0;
      vid_data_q  <= '0;
      rd_n_q      <= 1'b1;
      wr_n_q      <= 1'b1;
      ce_n_q      <= 1'b1;
      cpu_ack_q   <= 1'b0;
      vid_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      last_vid_q  <= last_vid_d;
      ram_addr_q  <= ram_addr_d;
      ram_din_q   <= ram_din_d;
      cpu_dout_q  <= cpu_dout_d;
      vid_data_q  <= vid_data_d;
      rd_n_q      <= rd_n_d;
      wr_n_q      <= wr_n_d;
      ce_n_q      <= ce_n_d;
      cpu_ack_q   <= cpu_ack_d;
      vid_valid_q <= vid_valid_d;
    end
  end

  assign bus.ram_addr  = ram_addr_q;
  assign bus.ram_din   = ram_din_q;
  assign bus.ram_rd_n  = rd_n_q;
  assign bus.ram_wr_n  = wr_n_q;
  assign bus.ram_ce_n  = ce_n_q;
  assign bus.cpu_dout  = cpu_dout_q;
  assign bus.cpu_ack   = cpu_ack_q;
  assign bus.cpu_wait  = bus.cpu_req & ~cpu_ack_q;
  assign bus.vid_q     = vid_data_q;
  assign bus.vid_valid = vid_valid_q;

endmodule
